// File: rtl/apb_fifo_bridge.sv
// APB3 slave fronting a TX FIFO (APB -> stream) and an RX FIFO (stream -> APB),
// with programmable wait states, bus error reporting, flush and a level IRQ.
module apb_fifo_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [3:0]     WS       = 4'(WAIT_STATES);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]       tx_count, rx_count;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [1:0]        ctrl;

  logic              addr_ok;
  logic [1:0]        reg_sel;
  logic              bus_err;
  logic [DATA_W-1:0] rd_data;
  logic              commit, wr_ok, rd_ok;
  logic              tx_push, tx_pop, tx_flush;
  logic              rx_push, rx_pop, rx_flush;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr];

  assign addr_ok  = ((PADDR >> 4) == '0);
  assign reg_sel  = PADDR[3:2];

  assign PREADY   = (state == ACCESS) && (wait_cnt == WS);
  assign PRDATA   = PREADY ? rd_data : '0;
  assign PSLVERR  = PREADY && bus_err;

  // A transfer only has side effects on the edge that completes it, and only if it was legal.
  assign commit   = (state == ACCESS) && PSEL && PENABLE && PREADY;
  assign wr_ok    = commit && PWRITE && !bus_err;
  assign rd_ok    = commit && !PWRITE && !bus_err;

  assign tx_push  = wr_ok && (reg_sel == 2'd0);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_flush = wr_ok && (reg_sel == 2'd3) && PWDATA[8];
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_ok && (reg_sel == 2'd1);
  assign rx_flush = wr_ok && (reg_sel == 2'd3) && PWDATA[9];

  // APB state and wait-state counter register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: setup phase enters ACCESS, completion or a dropped PSEL returns to IDLE.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt    = ACCESS;
          wait_cnt_nxt = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PREADY) begin
          if (PENABLE) state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register decode: error detection and read data mux, both from pre-edge state.
  always_comb begin
    bus_err = 1'b0;
    rd_data = '0;
    if (!addr_ok) begin
      bus_err = 1'b1;
    end else begin
      case (reg_sel)
        2'd0: bus_err = !PWRITE || tx_full;
        2'd1: begin
          if (PWRITE || rx_empty) bus_err = 1'b1;
          else                    rd_data = rx_mem[rx_rd_ptr];
        end
        2'd2: begin
          if (PWRITE) begin
            bus_err = 1'b1;
          end else begin
            rd_data[0]     = tx_full;
            rd_data[1]     = tx_empty;
            rd_data[2]     = rx_full;
            rd_data[3]     = rx_empty;
            rd_data[15:8]  = 8'(tx_count);
            rd_data[23:16] = 8'(rx_count);
          end
        end
        default: begin
          if (!PWRITE) rd_data[1:0] = ctrl;
        end
      endcase
    end
  end

  // Interrupt enables; the flush bits are pulses and are never stored.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                         ctrl <= '0;
    else if (wr_ok && reg_sel == 2'd3)  ctrl <= PWDATA[1:0];
  end

  // TX FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET || tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // RX FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET || rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= PWDATA;
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // Level interrupt, registered from the current FIFO state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) irq <= 1'b0;
    else        irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty);
  end

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Directed bench for apb_fifo_bridge with DEPTH=4 and WAIT_STATES=2.
module tb_apb_fifo_bridge;

  logic        PCLK, PRESET;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int testsRun  = 0;
  int failCount = 0;

  apb_fifo_bridge #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .WAIT_STATES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full APB transfer; optionally pulses tx_ready on exactly the completing edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                               input logic popOnCommit, output logic [31:0] rdata,
                               output logic err, output int waits);
    @(negedge PCLK);
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    waits = 0;
    while (!PREADY && waits < 20) begin
      @(negedge PCLK);
      waits++;
    end
    if (!PREADY) checkOutput("apb_timeout", {31'b0, PREADY}, 32'd1);
    rdata = PRDATA;
    err   = PSLVERR;
    if (popOnCommit) tx_ready = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (popOnCommit) tx_ready = 1'b0;
  endtask

  task automatic apbWrite(input logic [7:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] r;
    int w;
    applyStimulus(addr, 1'b1, wdata, 1'b0, r, err, w);
  endtask

  task automatic apbRead(input logic [7:0] addr, output logic [31:0] rdata, output logic err);
    int w;
    applyStimulus(addr, 1'b0, 32'd0, 1'b0, rdata, err, w);
  endtask

  // Single-cycle stream handshakes, started just after a rising edge.
  task automatic pushRx(input logic [31:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge PCLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic popTx();
    tx_ready = 1'b1;
    @(posedge PCLK);
    #1;
    tx_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  logic [7:0]  badAddr [3] = '{8'h00, 8'h04, 8'h08};
  logic        badWr   [3] = '{1'b0, 1'b1, 1'b1};

  initial begin
    PRESET = 1'b1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;
    #3;
    checkOutput("rst_pready",  {31'b0, PREADY}, 0);
    checkOutput("rst_prdata",  PRDATA, 0);
    checkOutput("rst_pslverr", {31'b0, PSLVERR}, 0);
    checkOutput("rst_irq",     {31'b0, irq}, 0);
    checkOutput("rst_txvalid", {31'b0, tx_valid}, 0);
    checkOutput("rst_rxready", {31'b0, rx_ready}, 1);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;

    // Wait-state insertion on a TX push.
    applyStimulus(8'h00, 1'b1, 32'hA5A5_0001, 1'b0, rd, err, waits);
    checkOutput("t1_waits",   waits, 2);
    checkOutput("t1_err",     {31'b0, err}, 0);
    checkOutput("t1_txvalid", {31'b0, tx_valid}, 1);
    checkOutput("t1_txdata",  tx_data, 32'hA5A5_0001);

    // Flush TX, then fill it and overflow it.
    apbWrite(8'h0C, 32'h100, err);
    checkOutput("t2_flush_err", {31'b0, err}, 0);
    checkOutput("t2_flushed",   {31'b0, tx_valid}, 0);
    for (int i = 1; i <= 5; i++) begin
      apbWrite(8'h00, 32'h10 + i, err);
      checkOutput($sformatf("t2_wr%0d_err", i), {31'b0, err}, (i == 5) ? 32'd1 : 32'd0);
    end
    apbRead(8'h08, rd, err);
    // tx_count=4, tx_full=1, rx_empty=1 -> 0x0409
    checkOutput("t2_status", rd, 32'h0000_0409);
    checkOutput("t2_head",   tx_data, 32'h11);
    // Full is judged before the edge, even when the stream drains on that edge.
    applyStimulus(8'h00, 1'b1, 32'h99, 1'b1, rd, err, waits);
    checkOutput("t2_full_drain_err", {31'b0, err}, 1);
    apbRead(8'h08, rd, err);
    checkOutput("t2_status_cnt3", rd, 32'h0000_0308);
    checkOutput("t2_head2", tx_data, 32'h12);

    // Simultaneous push and pop keep the count and the order.
    popTx();
    checkOutput("t4_head_pre", tx_data, 32'h13);
    applyStimulus(8'h00, 1'b1, 32'h15, 1'b1, rd, err, waits);
    checkOutput("t4_err", {31'b0, err}, 0);
    apbRead(8'h08, rd, err);
    checkOutput("t4_status_cnt2", rd, 32'h0000_0208);
    checkOutput("t4_head_a", tx_data, 32'h14);
    popTx();
    checkOutput("t4_head_b", tx_data, 32'h15);
    popTx();
    checkOutput("t4_drained", {31'b0, tx_valid}, 0);

    // RX empty read, then a real pop.
    apbRead(8'h04, rd, err);
    checkOutput("t3_empty_err",  {31'b0, err}, 1);
    checkOutput("t3_empty_data", rd, 0);
    pushRx(32'h1234);
    apbRead(8'h04, rd, err);
    checkOutput("t3_data", rd, 32'h1234);
    checkOutput("t3_err",  {31'b0, err}, 0);
    apbRead(8'h08, rd, err);
    checkOutput("t3_status", rd, 32'h0000_000A);

    // Illegal accesses to defined registers.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(badAddr[i], badWr[i], 32'h5, 1'b0, rd, err, waits);
      checkOutput($sformatf("bad_access%0d", i), {31'b0, err}, 1);
    end

    // Interrupt latency, clearing by pop, and RX flush beating a same-cycle push.
    apbWrite(8'h0C, 32'h1, err);
    pushRx(32'h55);
    checkOutput("t5_irq_lat0", {31'b0, irq}, 0);
    @(posedge PCLK); #1;
    checkOutput("t5_irq_set", {31'b0, irq}, 1);
    apbRead(8'h04, rd, err);
    checkOutput("t5_pop_data", rd, 32'h55);
    checkOutput("t5_irq_hold", {31'b0, irq}, 1);
    @(posedge PCLK); #1;
    checkOutput("t5_irq_clr", {31'b0, irq}, 0);
    rx_data = 32'h77; rx_valid = 1'b1;
    apbWrite(8'h0C, 32'h201, err);
    rx_valid = 1'b0;
    checkOutput("t5_flush_err", {31'b0, err}, 0);
    apbRead(8'h08, rd, err);
    checkOutput("t5_status", rd, 32'h0000_000A);
    apbRead(8'h0C, rd, err);
    checkOutput("t5_ctrl", rd, 32'h1);

    // A dropped PSEL aborts without pushing.
    @(negedge PCLK);
    PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'hDEAD; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    checkOutput("abort_no_push", {31'b0, tx_valid}, 0);

    // Unmapped address, then reset in the middle of an access.
    pushRx(32'hAB);
    apbWrite(8'h00, 32'hCD, err);
    checkOutput("t6_irq_pre", {31'b0, irq}, 1);
    apbRead(8'h10, rd, err);
    checkOutput("t6_bad_err",  {31'b0, err}, 1);
    checkOutput("t6_bad_data", rd, 0);
    @(negedge PCLK);
    PADDR = 8'h04; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge PCLK); PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESET = 1'b1;
    #1;
    checkOutput("t6_pready",  {31'b0, PREADY}, 0);
    checkOutput("t6_prdata",  PRDATA, 0);
    checkOutput("t6_pslverr", {31'b0, PSLVERR}, 0);
    checkOutput("t6_irq",     {31'b0, irq}, 0);
    checkOutput("t6_txvalid", {31'b0, tx_valid}, 0);
    checkOutput("t6_rxready", {31'b0, rx_ready}, 1);
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESET = 1'b0;
    apbRead(8'h08, rd, err);
    checkOutput("t6_status", rd, 32'h0000_000A);
    apbRead(8'h0C, rd, err);
    checkOutput("t6_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
